// File: rtl/fpu_divsqrt_sched_if.sv
// Handshake bundle between the FPU lane issue ports, the div/sqrt scheduler and the shared unit.
// master: lane/issue side driving requests; slave: the scheduler.
interface fpu_divsqrt_sched_if;
    logic        flush;
    logic [2:0]  req_en;
    logic [41:0] req_tag;
    logic [2:0]  req_sqrt;
    logic [2:0]  req_dbl;
    logic [2:0]  req_rdy;
    logic        du_start;
    logic        du_abort;
    logic [1:0]  du_lane;
    logic        du_sqrt;
    logic        du_dbl;
    logic [13:0] ret;
    logic        ret_en;
    logic [1:0]  ret_lane;

    modport master (
        output flush, req_en, req_tag, req_sqrt, req_dbl,
        input  req_rdy, du_start, du_abort, du_lane, du_sqrt, du_dbl, ret, ret_en, ret_lane
    );

    modport slave (
        input  flush, req_en, req_tag, req_sqrt, req_dbl,
        output req_rdy, du_start, du_abort, du_lane, du_sqrt, du_dbl, ret, ret_en, ret_lane
    );
endinterface

// File: rtl/fpu_divsqrt_sched.sv
// Round-robin scheduler sharing one iterative FP div/sqrt unit among three FPU lanes.
// Optional macro FPU_DIVSQRT_B2B_EN: drop the GAP bubble and grant back-to-back on completion.
module fpu_divsqrt_sched #(
    parameter int unsigned LAT_DIV_S  = 12,
    parameter int unsigned LAT_DIV_D  = 20,
    parameter int unsigned LAT_SQRT_S = 14,
    parameter int unsigned LAT_SQRT_D = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fpu_divsqrt_sched_if.slave io_bus
);

    typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

    state_e      r_state;
    logic [2:0]  r_hold_v;
    logic [2:0]  r_hold_sqrt;
    logic [2:0]  r_hold_dbl;
    logic [13:0] r_hold_tag [3];
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_lane;
    logic [4:0]  r_cnt;
    logic        r_sqrt;
    logic        r_dbl;
    logic [13:0] r_tag;

    logic        w_done;
    logic        w_can_grant;
    logic        w_grant;
    logic        w_ret_en;
    logic        w_run;
    logic        w_win_v;
    logic [1:0]  w_base;
    logic [1:0]  w_win_lane;

    function automatic logic [1:0] lane_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [4:0] lat_m1(input logic sqrt, input logic dbl);
        int unsigned l;
        case ({sqrt, dbl})
            2'b00:   l = LAT_DIV_S;
            2'b01:   l = LAT_DIV_D;
            2'b10:   l = LAT_SQRT_S;
            default: l = LAT_SQRT_D;
        endcase
        return 5'(l - 1);
    endfunction

    assign w_done = (r_state == StRun) && (r_cnt == 5'd0);
    assign w_run  = i_rst_n && (r_state == StRun);

`ifdef FPU_DIVSQRT_B2B_EN
    // On completion the scan starts after the retiring lane, ahead of the pointer update.
    assign w_can_grant = (r_state == StIdle) || w_done;
    assign w_base      = w_done ? lane_add(r_lane, 2'd1) : r_rr_ptr;
`else
    assign w_can_grant = (r_state == StIdle);
    assign w_base      = r_rr_ptr;
`endif

    always_comb begin
        w_win_v    = 1'b0;
        w_win_lane = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!w_win_v && r_hold_v[lane_add(w_base, 2'(k))]) begin
                w_win_v    = 1'b1;
                w_win_lane = lane_add(w_base, 2'(k));
            end
        end
    end

    assign w_grant  = i_rst_n && !io_bus.flush && w_can_grant && w_win_v;
    assign w_ret_en = i_rst_n && !io_bus.flush && w_done;

    assign io_bus.req_rdy  = ~r_hold_v;
    assign io_bus.du_start = w_grant;
    assign io_bus.du_abort = i_rst_n && io_bus.flush && (r_state == StRun);
    assign io_bus.du_lane  = w_grant ? w_win_lane : (w_run ? r_lane : 2'd0);
    assign io_bus.du_sqrt  = w_grant ? r_hold_sqrt[w_win_lane] : (w_run && r_sqrt);
    assign io_bus.du_dbl   = w_grant ? r_hold_dbl[w_win_lane] : (w_run && r_dbl);
    assign io_bus.ret_en   = w_ret_en;
    assign io_bus.ret      = w_ret_en ? r_tag : 14'd0;
    assign io_bus.ret_lane = w_ret_en ? r_lane : 2'd0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_hold_v    <= '0;
            r_hold_sqrt <= '0;
            r_hold_dbl  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_hold_tag[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_lane      <= '0;
            r_cnt       <= '0;
            r_sqrt      <= 1'b0;
            r_dbl       <= 1'b0;
            r_tag       <= '0;
        end else if (io_bus.flush) begin
            r_state  <= StIdle;
            r_hold_v <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_grant && (w_win_lane == 2'(i))) begin
                    r_hold_v[i] <= 1'b0;
                end else if (io_bus.req_en[i] && !r_hold_v[i]) begin
                    r_hold_v[i]    <= 1'b1;
                    r_hold_tag[i]  <= io_bus.req_tag[14*i +: 14];
                    r_hold_sqrt[i] <= io_bus.req_sqrt[i];
                    r_hold_dbl[i]  <= io_bus.req_dbl[i];
                end
            end
            if (w_done) begin
                r_rr_ptr <= lane_add(r_lane, 2'd1);
            end
            if (w_grant) begin
                r_state <= StRun;
                r_lane  <= w_win_lane;
                r_sqrt  <= r_hold_sqrt[w_win_lane];
                r_dbl   <= r_hold_dbl[w_win_lane];
                r_tag   <= r_hold_tag[w_win_lane];
                r_cnt   <= lat_m1(r_hold_sqrt[w_win_lane], r_hold_dbl[w_win_lane]);
            end else begin
                case (r_state)
                    StRun: begin
                        if (w_done) begin
`ifdef FPU_DIVSQRT_B2B_EN
                            r_state <= StIdle;
`else
                            r_state <= StGap;
`endif
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    StGap:   r_state <= StIdle;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_divsqrt_sched.sv
// Scoreboard bench for fpu_divsqrt_sched: a timestamp-based model predicts grants and retires.
module tb_fpu_divsqrt_sched;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  lane;
        logic        sqrt;
        logic        dbl;
    } start_t;

    typedef struct {
        int unsigned cyc;
        logic [13:0] tag;
        logic [1:0]  lane;
    } ret_t;

`ifdef FPU_DIVSQRT_B2B_EN
    localparam int unsigned GapCycles = 0;
`else
    localparam int unsigned GapCycles = 2;
`endif

    logic clk;
    logic rst_n;

    fpu_divsqrt_sched_if bus ();

    fpu_divsqrt_sched dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    start_t      start_q [$];
    ret_t        ret_q [$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference state: slots plus absolute cycle stamps instead of a down-counter.
    logic [2:0]  m_hv = '0;
    logic [13:0] m_htag [3];
    logic [2:0]  m_hs = '0;
    logic [2:0]  m_hd = '0;
    int unsigned m_ptr = 0;
    int unsigned m_lane = 0;
    bit          m_busy = 1'b0;
    int unsigned m_done = 0;
    int unsigned m_free = 0;
    logic [2:0]  e_rdy = 3'b111;
    logic        e_abort = 1'b0;

    function automatic int unsigned op_lat(input logic s, input logic d);
        if (!s && !d) return 12;
        if (!s && d)  return 20;
        if (s && !d)  return 14;
        return 24;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endfunction

    task automatic model_cycle();
        int unsigned n;
        logic [2:0]  hv_old;
        int unsigned w;
        bit          found;
        n       = cyc;
        hv_old  = m_hv;
        e_rdy   = ~hv_old;
        e_abort = 1'b0;
        if (!rst_n || bus.flush) begin
            if (m_busy) begin
                e_abort = rst_n;
                void'(ret_q.pop_back());
            end
            m_hv   = '0;
            m_busy = 1'b0;
            m_free = n + 1;
            if (!rst_n) m_ptr = 0;
            return;
        end
        if (m_busy && m_done == n) begin
            m_ptr  = (m_lane + 1) % 3;
            m_busy = 1'b0;
            m_free = n + GapCycles;
        end
        if (!m_busy && n >= m_free && m_hv != 3'b000) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < 3; k++) begin
                if (!found && m_hv[(m_ptr + k) % 3]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % 3;
                end
            end
            start_q.push_back('{cyc: n, lane: 2'(w), sqrt: m_hs[w], dbl: m_hd[w]});
            ret_q.push_back('{cyc: n + op_lat(m_hs[w], m_hd[w]), tag: m_htag[w], lane: 2'(w)});
            m_busy = 1'b1;
            m_lane = w;
            m_done = n + op_lat(m_hs[w], m_hd[w]);
            m_hv[w] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.req_en[i] && !hv_old[i]) begin
                m_hv[i]   = 1'b1;
                m_htag[i] = bus.req_tag[14*i +: 14];
                m_hs[i]   = bus.req_sqrt[i];
                m_hd[i]   = bus.req_dbl[i];
            end
        end
    endtask

    task automatic step(input logic rn, input logic fl, input logic [2:0] en,
                        input logic [41:0] tags, input logic [2:0] s, input logic [2:0] d);
        @(posedge clk);
        #1;
        rst_n        = rn;
        bus.flush    = fl;
        bus.req_en   = en;
        bus.req_tag  = tags;
        bus.req_sqrt = s;
        bus.req_dbl  = d;
        cyc++;
        model_cycle();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 3'b000, 42'd0, 3'b000, 3'b000);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a start or a retire.
    initial begin
        wait (cyc >= 1);
        forever begin
            @(negedge clk);
            check("req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
            check("du_abort", 32'(bus.du_abort), 32'(e_abort));
            if (start_q.size() != 0 && start_q[0].cyc < cyc) begin
                check("du_start_missed", 32'(start_q[0].cyc), 32'(cyc));
                void'(start_q.pop_front());
            end
            if (bus.du_start) begin
                if (start_q.size() == 0 || start_q[0].cyc != cyc) begin
                    check("du_start_unexpected", 32'(bus.du_start), 32'd0);
                end else begin
                    check("du_lane", 32'(bus.du_lane), 32'(start_q[0].lane));
                    check("du_op", 32'({bus.du_sqrt, bus.du_dbl}),
                          32'({start_q[0].sqrt, start_q[0].dbl}));
                    void'(start_q.pop_front());
                end
            end
            if (ret_q.size() != 0 && ret_q[0].cyc < cyc) begin
                check("ret_missed", 32'(ret_q[0].cyc), 32'(cyc));
                void'(ret_q.pop_front());
            end
            if (bus.ret_en) begin
                if (ret_q.size() == 0 || ret_q[0].cyc != cyc) begin
                    check("ret_en_unexpected", 32'(bus.ret_en), 32'd0);
                end else begin
                    check("ret_tag", 32'(bus.ret), 32'(ret_q[0].tag));
                    check("ret_lane", 32'(bus.ret_lane), 32'(ret_q[0].lane));
                    void'(ret_q.pop_front());
                end
            end else begin
                check("ret_idle_zero", 32'({bus.ret, bus.ret_lane}), 32'd0);
            end
        end
    end

    initial begin
        logic [41:0] tags;
        logic [2:0]  en;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.req_en   = '0;
        bus.req_tag  = '0;
        bus.req_sqrt = '0;
        bus.req_dbl  = '0;
        step(1'b0, 1'b0, 3'b000, 42'd0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 3'b000, 42'd0, 3'b000, 3'b000);
        // Single lane0 divide single, tag 0x0155.
        step(1'b1, 1'b0, 3'b001, {28'd0, 14'h0155}, 3'b000, 3'b000);
        idle(20);
        // All lanes sqrt double together.
        step(1'b1, 1'b0, 3'b111, {14'h2222, 14'h1111, 14'h0AAA}, 3'b111, 3'b111);
        idle(90);
        // Lane2 runs; lanes 0 and 2 wait, lane0 should win next.
        step(1'b1, 1'b0, 3'b100, {14'h0321, 28'd0}, 3'b000, 3'b000);
        step(1'b1, 1'b0, 3'b101, {14'h0654, 14'h0000, 14'h0987}, 3'b000, 3'b000);
        idle(50);
        // Flush at cnt==3 of a lane1 divide double with lane0 held.
        step(1'b1, 1'b0, 3'b010, {14'd0, 14'h1DD1, 14'd0}, 3'b000, 3'b010);
        step(1'b1, 1'b0, 3'b001, {28'd0, 14'h0F0F}, 3'b000, 3'b000);
        idle(16);
        step(1'b1, 1'b1, 3'b000, 42'd0, 3'b000, 3'b000);
        idle(5);
        // Request into a full slot is ignored.
        step(1'b1, 1'b0, 3'b010, {14'd0, 14'h0101, 14'd0}, 3'b000, 3'b000);
        step(1'b1, 1'b0, 3'b001, {28'd0, 14'h0AAA}, 3'b000, 3'b000);
        step(1'b1, 1'b0, 3'b001, {28'd0, 14'h3BBB}, 3'b000, 3'b000);
        idle(40);
        // Reset pulse mid-run.
        step(1'b1, 1'b0, 3'b001, {28'd0, 14'h1234}, 3'b001, 3'b000);
        idle(5);
        step(1'b0, 1'b0, 3'b000, 42'd0, 3'b000, 3'b000);
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            en   = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            tags = {14'($urandom), 14'($urandom), 14'($urandom)};
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0), en, tags,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle(120);
        check("start_q_drained", 32'(start_q.size()), 32'd0);
        check("ret_q_drained", 32'(ret_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
